// File: rtl/simplebus_mem_follower_if.sv
// Simple multiplexed bus, follower-facing view with tri-states split into
// explicit out/oe pairs so the bus wrapper performs the resolution.
//   start     : leader marks the first address cycle
//   read      : 1 = read, taken on the last address cycle
//   burst_len : beats-1, taken with start
//   address   : address byte, MSB byte first
//   data_in   : resolved bus data
//   data_out  : read data from the follower, qualified by data_oe
//   dv_in     : resolved dataValid
//   dv_out    : dataValid from the follower, qualified by dv_oe
//   busy      : follower is not idle
interface simplebus_mem_follower_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              start;
  logic              read;
  logic [1:0]        burst_len;
  logic [7:0]        address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;
  logic              dv_in;
  logic              dv_out;
  logic              dv_oe;
  logic              busy;

  modport slave (
    input  start, read, burst_len, address, data_in, dv_in,
    output data_out, data_oe, dv_out, dv_oe, busy
  );

  modport master (
    output start, read, burst_len, address, data_in, dv_in,
    input  data_out, data_oe, dv_out, dv_oe, busy
  );
endinterface

// File: rtl/simplebus_mem_follower.sv
// Memory follower for the simple multiplexed bus. Captures ADDR_BYTES address
// bytes (the first one is the device ID), then serves a read or write of one
// beat, or of 1..4 beats when SIMPLEBUS_BURST_EN is defined, against a local
// word array. Transactions for other device IDs are tracked silently by
// counting dataValid pulses.
//   clock : bus clock, rising edge
//   reset : synchronous, active-high
//   bus   : simplebus_mem_follower_if.slave (see interface for signals)
// Optional feature macro: SIMPLEBUS_BURST_EN (burst_len honoured when defined).
module simplebus_mem_follower #(
  parameter logic [7:0]        DEV_ID     = 8'd0,
  parameter int unsigned       ADDR_BYTES = 3,
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       MEM_AW     = 16,
  parameter int unsigned       READ_LAT   = 2,
  parameter logic [DATA_W-1:0] INIT_VAL   = DATA_W'(DEV_ID)
) (
  input logic                     clock,
  input logic                     reset,
  simplebus_mem_follower_if.slave bus
);
  localparam int unsigned DEPTH        = 1 << MEM_AW;
  localparam int unsigned SHIFT_FULL_W = 8 * (ADDR_BYTES - 1);
  // Only the address bits that can reach the array are kept.
  localparam int unsigned SHIFT_W      = (SHIFT_FULL_W < MEM_AW) ? SHIFT_FULL_W : MEM_AW;
  localparam int unsigned BEAT_W       = 3;
  localparam int unsigned BCNT_W       = 2;
  localparam int unsigned LAT_W        = 4;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_SKIP, ST_RLAT, ST_RDATA, ST_WDATA
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          id_q, id_d;
  logic [SHIFT_W-1:0]  shift_q, shift_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic [MEM_AW-1:0]   rd_addr_c;
  logic [BEAT_W-1:0]   beats_q, beats_d, beats_load_c;
  logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                drive_q, drive_d;
  logic                busy_q, busy_d;
  logic                rd_go_c;
  logic                mem_we_c;

  // Storage: preset to INIT_VAL at time zero, untouched by reset.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: INIT_VAL};

  // Beats per transaction.
`ifdef SIMPLEBUS_BURST_EN
  assign beats_load_c = BEAT_W'(bus.burst_len) + BEAT_W'(1);
`else
  logic unused_burst_c;
  assign beats_load_c   = BEAT_W'(1);
  assign unused_burst_c = ^bus.burst_len;
`endif

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      id_q       <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      beats_q    <= '0;
      byte_cnt_q <= '0;
      lat_q      <= '0;
      data_out_q <= '0;
      drive_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      beats_q    <= beats_d;
      byte_cnt_q <= byte_cnt_d;
      lat_q      <= lat_d;
      data_out_q <= data_out_d;
      drive_q    <= drive_d;
      busy_q     <= busy_d;
    end
  end

  // Next state; rd_go_c marks a read beat presented in the following cycle.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    beats_d    = beats_q;
    byte_cnt_d = byte_cnt_q;
    lat_d      = lat_q;
    rd_go_c    = 1'b0;
    rd_addr_c  = addr_q;
    mem_we_c   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          id_d       = bus.address;
          shift_d    = '0;
          beats_d    = beats_load_c;
          byte_cnt_d = BCNT_W'(ADDR_BYTES - 1);
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        shift_d = SHIFT_W'({shift_q, bus.address});
        if (byte_cnt_q == BCNT_W'(1)) begin
          addr_d = MEM_AW'(shift_d);
          if (id_q != DEV_ID) begin
            state_d = ST_SKIP;
          end else if (!bus.read) begin
            state_d = ST_WDATA;
          end else if (READ_LAT == 1) begin
            // No latency cycles: first beat follows the last address byte.
            rd_go_c   = 1'b1;
            rd_addr_c = MEM_AW'(shift_d);
            state_d   = ST_RDATA;
          end else begin
            lat_d   = LAT_W'(READ_LAT - 1);
            state_d = ST_RLAT;
          end
        end else begin
          byte_cnt_d = byte_cnt_q - BCNT_W'(1);
        end
      end
      ST_SKIP: begin
        if (bus.dv_in) begin
          if (beats_q == BEAT_W'(1)) state_d = ST_IDLE;
          else                       beats_d = beats_q - BEAT_W'(1);
        end
      end
      ST_RLAT: begin
        if (lat_q == LAT_W'(1)) begin
          rd_go_c = 1'b1;
          state_d = ST_RDATA;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      ST_RDATA: begin
        if (beats_q == BEAT_W'(0)) state_d = ST_IDLE;
        else                       rd_go_c = 1'b1;
      end
      ST_WDATA: begin
        if (bus.dv_in) begin
          mem_we_c = 1'b1;
          addr_d   = addr_q + MEM_AW'(1);
          if (beats_q == BEAT_W'(1)) state_d = ST_IDLE;
          else                       beats_d = beats_q - BEAT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Issuing a read beat consumes one beat and advances the address.
    if (rd_go_c) begin
      addr_d  = rd_addr_c + MEM_AW'(1);
      beats_d = beats_q - BEAT_W'(1);
    end

    data_out_d = rd_go_c ? mem_q[rd_addr_c] : '0;
    drive_d    = rd_go_c;
    busy_d     = (state_d != ST_IDLE);
  end

  // Array write port; a write coinciding with reset is dropped.
  always_ff @(posedge clock) begin
    if (mem_we_c && !reset) mem_q[addr_q] <= bus.data_in;
  end

  assign bus.data_out = data_out_q;
  assign bus.data_oe  = drive_q;
  assign bus.dv_out   = drive_q;
  assign bus.dv_oe    = drive_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_simplebus_mem_follower.sv
// Self-checking bench for simplebus_mem_follower: directed scenarios plus
// randomized read/write/foreign-ID transactions against a sparse memory model.
module tb_simplebus_mem_follower;
  localparam int         AB   = 3;
  localparam int         DW   = 8;
  localparam int         AW   = 16;
  localparam int         LAT  = 2;
  localparam logic [7:0] DEV  = 8'h01;
  localparam logic [7:0] INIT = 8'h01;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;

  // Sparse reference memory: absent entries read as INIT.
  logic [7:0] ref_mem [logic [15:0]];

  simplebus_mem_follower_if #(.DATA_W(DW)) bus ();

  simplebus_mem_follower #(
    .DEV_ID(DEV), .ADDR_BYTES(AB), .DATA_W(DW), .MEM_AW(AW), .READ_LAT(LAT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nbeats(input logic [1:0] bl);
`ifdef SIMPLEBUS_BURST_EN
    return int'(bl) + 1;
`else
    return 1 + 0 * int'(bl);
`endif
  endfunction

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return INIT;
  endfunction

  // Cycle 0 (start) through the last address cycle; returns with inputs
  // for the last address cycle applied.
  task automatic start_txn(input logic rd, input logic [7:0] id, input logic [15:0] a,
                           input logic [1:0] bl);
    logic [23:0] full;
    full = {id, a};
    @(negedge clock);
    check_eq("idle_before_start", 32'(bus.busy), 32'd0);
    bus.start     = 1'b1;
    bus.read      = 1'($urandom);
    bus.burst_len = bl;
    bus.address   = full[23:16];
    bus.dv_in     = 1'b0;
    bus.data_in   = 8'($urandom);
    for (int c = 1; c < AB; c++) begin
      @(negedge clock);
      check_eq("addr_busy", 32'(bus.busy), 32'd1);
      check_eq("addr_oe", 32'(bus.data_oe), 32'd0);
      bus.start     = 1'($urandom);
      bus.read      = (c == AB - 1) ? rd : 1'($urandom);
      bus.burst_len = 2'($urandom);
      bus.address   = full[8*(AB-1-c) +: 8];
    end
  endtask

  // Read to this device; rst_beat >= 0 asserts reset during that beat.
  task automatic read_txn(input logic [15:0] a, input logic [1:0] bl, input int rst_beat);
    int          n;
    int          first;
    logic        in_beat;
    logic [15:0] pa;
    n     = nbeats(bl);
    first = AB - 1 + LAT;
    start_txn(1'b1, DEV, a, bl);
    for (int c = AB; c < first + n; c++) begin
      @(negedge clock);
      bus.start   = 1'b0;
      bus.read    = 1'($urandom);
      bus.address = 8'($urandom);
      bus.dv_in   = 1'b0;
      in_beat = (c >= first);
      check_eq("rd_busy", 32'(bus.busy), 32'd1);
      check_eq("rd_data_oe", 32'(bus.data_oe), 32'(in_beat));
      check_eq("rd_dv_oe", 32'(bus.dv_oe), 32'(in_beat));
      check_eq("rd_dv_out", 32'(bus.dv_out), 32'(in_beat));
      if (in_beat) begin
        pa = a + 16'(c - first);
        check_eq("rd_data", 32'(bus.data_out), 32'(ref_rd(pa)));
        if (c - first == rst_beat) begin
          reset = 1'b1;
          @(negedge clock);
          reset = 1'b0;
          check_eq("rst_rd_busy", 32'(bus.busy), 32'd0);
          check_eq("rst_rd_data_oe", 32'(bus.data_oe), 32'd0);
          check_eq("rst_rd_dv_oe", 32'(bus.dv_oe), 32'd0);
          check_eq("rst_rd_dv_out", 32'(bus.dv_out), 32'd0);
          check_eq("rst_rd_data_out", 32'(bus.data_out), 32'd0);
          repeat (n) begin
            @(negedge clock);
            check_eq("post_rst_oe", 32'(bus.data_oe), 32'd0);
          end
          return;
        end
      end
    end
  endtask

  // Write to this device with gp[k] idle cycles before beat k; rst_beat >= 0
  // asserts reset together with that beat (the beat must not land).
  task automatic write_txn(input logic [15:0] a, input logic [1:0] bl, input logic [7:0] wd [4],
                           input int gp [4], input int rst_beat);
    int n;
    n = nbeats(bl);
    start_txn(1'b0, DEV, a, bl);
    for (int k = 0; k < n; k++) begin
      repeat (gp[k]) begin
        @(negedge clock);
        check_eq("wr_gap_busy", 32'(bus.busy), 32'd1);
        check_eq("wr_gap_oe", 32'(bus.dv_oe), 32'd0);
        bus.start   = 1'b0;
        bus.dv_in   = 1'b0;
        bus.data_in = 8'($urandom);
      end
      @(negedge clock);
      check_eq("wr_busy", 32'(bus.busy), 32'd1);
      check_eq("wr_oe", 32'(bus.data_oe), 32'd0);
      bus.start   = 1'b0;
      bus.dv_in   = 1'b1;
      bus.data_in = wd[k];
      if (k == rst_beat) begin
        reset = 1'b1;
        @(negedge clock);
        reset     = 1'b0;
        bus.dv_in = 1'b0;
        check_eq("rst_wr_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_wr_oe", 32'(bus.dv_oe), 32'd0);
        return;
      end
      ref_mem[a + 16'(k)] = wd[k];
    end
  endtask

  // Transaction for another device: stay silent, follow dv_in pulses.
  task automatic skip_txn(input logic [7:0] id, input logic rd, input logic [15:0] a,
                          input logic [1:0] bl);
    int n;
    n = nbeats(bl);
    start_txn(rd, id, a, bl);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clock);
        check_eq("skip_gap_busy", 32'(bus.busy), 32'd1);
        check_eq("skip_gap_oe", 32'(bus.data_oe), 32'd0);
        bus.start   = 1'b0;
        bus.dv_in   = 1'b0;
        bus.data_in = 8'($urandom);
      end
      @(negedge clock);
      check_eq("skip_busy", 32'(bus.busy), 32'd1);
      check_eq("skip_data_oe", 32'(bus.data_oe), 32'd0);
      check_eq("skip_dv_oe", 32'(bus.dv_oe), 32'd0);
      bus.start   = 1'b0;
      bus.dv_in   = 1'b1;
      bus.data_in = 8'($urandom);
    end
  endtask

  initial begin
    logic [7:0]  wd [4];
    int          gp [4];
    int          zg [4];
    int          kind;
    logic [15:0] a;
    logic [1:0]  bl;
    logic [7:0]  id;

    n_tests       = 0;
    n_fail        = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.read      = 1'b0;
    bus.burst_len = 2'd0;
    bus.address   = 8'd0;
    bus.data_in   = 8'd0;
    bus.dv_in     = 1'b0;
    zg            = '{0, 0, 0, 0};

    repeat (3) @(negedge clock);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_data_oe", 32'(bus.data_oe), 32'd0);
    check_eq("rst_dv_oe", 32'(bus.dv_oe), 32'd0);
    check_eq("rst_dv_out", 32'(bus.dv_out), 32'd0);
    check_eq("rst_data_out", 32'(bus.data_out), 32'd0);
    reset = 1'b0;

    // Single write then read-back, unwritten word, foreign ID.
    wd = '{8'hDC, 8'h00, 8'h00, 8'h00};
    write_txn(16'h0406, 2'd0, wd, zg, -1);
    read_txn(16'h0406, 2'd0, -1);
    read_txn(16'h0500, 2'd0, -1);
    skip_txn(8'h02, 1'b1, 16'h0406, 2'd0);

    // Four-beat write/read across the top of the array.
    wd = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    write_txn(16'hFFFE, 2'd3, wd, zg, -1);
    read_txn(16'hFFFE, 2'd3, -1);

    // Two-beat write with dv_in pattern 1,0,0,1.
    wd = '{8'h11, 8'h22, 8'h00, 8'h00};
    gp = '{0, 2, 0, 0};
    write_txn(16'h2000, 2'd1, wd, gp, -1);
    read_txn(16'h2000, 2'd1, -1);

    // Reset during the second beat of a burst read, then a clean read.
    read_txn(16'hFFFE, 2'd3, (nbeats(2'd3) > 1) ? 1 : 0);
    read_txn(16'h0406, 2'd0, -1);

    // Reset on the last beat of a write: that beat must not land.
    wd = '{8'h55, 8'h66, 8'h00, 8'h00};
    write_txn(16'h1230, 2'd1, wd, zg, nbeats(2'd1) - 1);
    read_txn(16'h1230, 2'd1, -1);

    // Random mix around the wrap point.
    for (int t = 0; t < 200; t++) begin
      kind = $urandom_range(0, 2);
      a    = 16'(32'hFFF0 + $urandom_range(0, 31));
      bl   = 2'($urandom);
      case (kind)
        0: begin
          for (int k = 0; k < 4; k++) begin
            wd[k] = 8'($urandom);
            gp[k] = $urandom_range(0, 2);
          end
          write_txn(a, bl, wd, gp, -1);
        end
        1: read_txn(a, bl, -1);
        default: begin
          id = 8'($urandom);
          if (id == DEV) id = 8'h00;
          skip_txn(id, 1'($urandom), a, bl);
        end
      endcase
    end

    @(negedge clock);
    check_eq("final_idle", 32'(bus.busy), 32'd0);
    bus.dv_in = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/simplebus_mem_follower.md
# simplebus_mem_follower

Parametrised memory follower for the simple multiplexed bus: captures a multi-byte address over consecutive bus cycles, decodes a device ID from the top address byte, and services single or burst reads/writes against a local word array. It is the next-generation replacement for the fixed 3-byte, 8-bit, random-latency memory thread. It sits on the follower side of the bus, one instance per device ID. Tri-state is split into explicit out/oe pairs so the bus wrapper does the resolution.

## Interface
- DEV_ID, 0, value of the top address byte that selects this follower (8 bits)
- ADDR_BYTES, 3, address bytes per transaction, 2..4; first byte is the device ID
- DATA_W, 8, data word width
- MEM_AW, 16, local array address width; depth = 2**MEM_AW words
- READ_LAT, 2, cycles from last address cycle to first read beat, 1..15
- INIT_VAL, DEV_ID, value every word holds at time zero (simulation init)

Ports:
- clock  in  1  bus clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  leader marks first address cycle
- read  in  1  1 = read, sampled on last address cycle
- burst_len  in  2  beats-1, sampled with start (used only with burst feature)
- address  in  8  address byte, MSB byte first
- data_in  in  DATA_W  resolved bus data
- data_out  out  DATA_W  read data driven by this follower
- data_oe  out  1  enable for data_out
- dv_in  in  1  resolved dataValid
- dv_out  out  1  dataValid driven by this follower
- dv_oe  out  1  enable for dv_out
- busy  out  1  follower not in IDLE

## Operation
- States: IDLE, ADDR, SKIP, RLAT, RDATA, WDATA.
- IDLE: start=1 → load address byte into ID register, latch burst_len, beat counter = burst_len+1, go ADDR with byte count ADDR_BYTES-1. start in any other state is ignored.
- ADDR: shift one address byte per cycle, MSB first. On the last byte: ID ≠ DEV_ID → SKIP; else read=1 → RLAT (counter READ_LAT-1) or read=0 → WDATA.
- Word address = low MEM_AW bits of the concatenated lower (ADDR_BYTES-1) bytes; missing upper bits zero-extended.
- SKIP: outputs stay inactive; count dv_in=1 cycles; after beats count seen → IDLE.
- RLAT: count down; at zero → RDATA.
- RDATA: one beat per cycle, consecutive: data_out=mem[addr], data_oe=dv_oe=dv_out=1; addr+1 mod 2**MEM_AW; after last beat → IDLE.
- WDATA: each cycle with dv_in=1 write data_in to mem[addr], addr+1 mod 2**MEM_AW, decrement beats; after last beat → IDLE. No timeout; dv_in=0 cycles hold.
- dv_oe only in RDATA; this follower never drives dataValid during writes.
- Memory contents not affected by reset.

## Timing
- Reset: state IDLE, data_out=0, data_oe=0, dv_out=0, dv_oe=0, busy=0 one edge after reset sampled high; any transaction (including mid-burst) abandoned, no further writes.
- All outputs registered. Cycle 0 = start cycle; last address cycle = ADDR_BYTES-1.
- Read: first beat valid in cycle ADDR_BYTES-1+READ_LAT; beat k in cycle ADDR_BYTES-1+READ_LAT+k; busy drops the cycle after the last beat.
- Write: earliest data beat accepted in cycle ADDR_BYTES (cycle after last address byte); write visible to a read issued afterwards.
- busy high from cycle 1 through end of transaction.
- Next start accepted in the first cycle busy=0.

## Configuration
- SIMPLEBUS_BURST_EN defined: burst_len honoured, 1–4 beats per transaction with address increment and wrap.
- Undefined: burst_len ignored, every transaction exactly one beat; port still present.

## Test plan
- DEV_ID=1, write addr 24'h010406 data 8'hDC, then read 24'h010406 → RDATA beat 8'hDC in cycle 2+READ_LAT (cycle 4 at default).
- Read unwritten 24'h010500 on DEV_ID=1 → 8'h01 (INIT_VAL); read 24'h020406 → dv_oe/data_oe never asserted, busy returns to 0 after one dv_in pulse.
- SIMPLEBUS_BURST_EN, burst_len=3 write 8'hA0..A3 at 16'hFFFE then burst read → beats A0,A1,A2,A3 from addresses FFFE,FFFF,0000,0001 (wrap).
- Write with dv_in gapped (1,0,0,1) for 2-beat burst → exactly 2 writes, busy held through gaps.
- reset=1 during beat 2 of 4-beat read → next cycle all outputs 0, IDLE; beats 3–4 never driven; subsequent single read correct.
- Without SIMPLEBUS_BURST_EN, burst_len=3 read → exactly one beat, busy low next cycle.
